// File: rtl/simd_mac_pipelined_param.sv
// Pipelined multiply-accumulate built from LANE x LANE sub-multipliers: one wide
// FULL product, or NB isolated SIMD dot-product channels, with per-channel accumulators.
module simd_mac_pipelined_param #(
  parameter int LANE        = 9,
  parameter int NA          = 3,
  parameter int NB          = 2,
  parameter int PIPE_STAGES = 2,
  parameter int ACC_W       = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NA*NB*LANE-1:0]  a,
  input  logic [NA*NB*LANE-1:0]  b,
  input  logic                   a_sign,
  input  logic                   b_sign,
  input  logic                   mode,
  input  logic                   first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB*ACC_W-1:0]    result,
  output logic [NB-1:0]          overflow,
  output logic                   out_mode
);

  localparam int A_W  = NA * LANE;
  localparam int B_W  = NB * LANE;
  localparam int AB_W = A_W + B_W;
  localparam int NP   = NA * NB;
  localparam int PW   = 2 * LANE + 2;
  localparam int LAST = PIPE_STAGES - 1;

  // Handshake: a beat moves on an edge where valid and ready are both high;
  // every stage advances together on en_w, so a stalled output freezes the whole pipe.
  logic en_w;
  logic out_valid_q;

  assign en_w     = ~out_valid_q | out_ready;
  assign in_ready = en_w;

  function automatic logic [PW-1:0] lane_prod(input logic [LANE-1:0] x, input logic sx,
                                              input logic [LANE-1:0] y, input logic sy);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = {{(PW-LANE){sx & x[LANE-1]}}, x};
    ye = {{(PW-LANE){sy & y[LANE-1]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [ACC_W-1:0] ext_acc(input logic [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  function automatic logic [AB_W-1:0] ext_ab(input logic [PW-1:0] p);
    return {{(AB_W-PW){p[PW-1]}}, p};
  endfunction

  // Product m pairs A lane (m % NA) with B lane (m / NA) in FULL mode, and
  // lane m of both operands in SIMD mode, so channel j owns products j*NA .. j*NA+NA-1.
  logic [NP*PW-1:0] prod_d;

  always_comb begin
    prod_d = '0;
    for (int m = 0; m < NP; m++) begin
      if (mode)
        prod_d[m*PW +: PW] = lane_prod(a[m*LANE +: LANE], a_sign,
                                       b[m*LANE +: LANE], b_sign);
      else
        prod_d[m*PW +: PW] = lane_prod(a[(m % NA)*LANE +: LANE], a_sign & ((m % NA) == NA-1),
                                       b[(m / NA)*LANE +: LANE], b_sign & ((m / NA) == NB-1));
    end
  end

  logic [NP*PW-1:0]       prod_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pv_q;
  logic [PIPE_STAGES-1:0] pm_q;
  logic [PIPE_STAGES-1:0] ps_q;
  logic [PIPE_STAGES-1:0] pf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      pm_q <= '0;
      ps_q <= '0;
      pf_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) prod_q[s] <= '0;
    end else if (en_w) begin
      pv_q[0]   <= in_valid;
      pm_q[0]   <= mode;
      ps_q[0]   <= a_sign | b_sign;
      pf_q[0]   <= first;
      prod_q[0] <= prod_d;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pv_q[s]   <= pv_q[s-1];
        pm_q[s]   <= pm_q[s-1];
        ps_q[s]   <= ps_q[s-1];
        pf_q[s]   <= pf_q[s-1];
        prod_q[s] <= prod_q[s-1];
      end
    end
  end

  // Reduction: SIMD channels are summed separately in ACC_W so no carry crosses
  // channels; FULL shifts every partial product into one AB_W-bit product.
  logic [NB*ACC_W-1:0] sum_d;
  logic [ACC_W-1:0]    chan_w;
  logic [AB_W-1:0]     full_w;

  always_comb begin
    sum_d  = '0;
    chan_w = '0;
    full_w = '0;
    if (pm_q[LAST]) begin
      for (int j = 0; j < NB; j++) begin
        chan_w = '0;
        for (int i = 0; i < NA; i++)
          chan_w = chan_w + ext_acc(prod_q[LAST][(j*NA+i)*PW +: PW]);
        sum_d[j*ACC_W +: ACC_W] = chan_w;
      end
    end else begin
      for (int m = 0; m < NP; m++)
        full_w = full_w + (ext_ab(prod_q[LAST][m*PW +: PW]) << ((m % NA + m / NA) * LANE));
      sum_d[ACC_W-1:0] = {{(ACC_W-AB_W){ps_q[LAST] & full_w[AB_W-1]}}, full_w};
    end
  end

  logic                sv_q;
  logic                sm_q;
  logic                ss_q;
  logic                sf_q;
  logic [NB*ACC_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_q  <= 1'b0;
      sm_q  <= 1'b0;
      ss_q  <= 1'b0;
      sf_q  <= 1'b0;
      sum_q <= '0;
    end else if (en_w) begin
      sv_q  <= pv_q[LAST];
      sm_q  <= pm_q[LAST];
      ss_q  <= ps_q[LAST];
      sf_q  <= pf_q[LAST];
      sum_q <= sum_d;
    end
  end

  // A beat reloads the accumulators when flagged first, when the mode changes,
  // or when it is the first beat to reach this stage since reset.
  logic                load_w;
  logic [ACC_W:0]      add_w;
  logic [ACC_W-1:0]    x_w;
  logic [ACC_W-1:0]    y_w;
  logic [NB*ACC_W-1:0] acc_d;
  logic [NB*ACC_W-1:0] acc_q;
  logic [NB-1:0]       ovf_d;
  logic [NB-1:0]       ovf_q;
  logic                out_mode_q;
  logic                seen_q;

  always_comb begin
    load_w = sf_q | ~seen_q | (sm_q != out_mode_q);
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    add_w  = '0;
    x_w    = '0;
    y_w    = '0;
    for (int j = 0; j < NB; j++) begin
      x_w   = acc_q[j*ACC_W +: ACC_W];
      y_w   = sum_q[j*ACC_W +: ACC_W];
      add_w = {1'b0, x_w} + {1'b0, y_w};
      if (load_w) begin
        acc_d[j*ACC_W +: ACC_W] = y_w;
        ovf_d[j]                = 1'b0;
      end else begin
        acc_d[j*ACC_W +: ACC_W] = add_w[ACC_W-1:0];
        ovf_d[j] = ovf_q[j] | (ss_q ? ((x_w[ACC_W-1] == y_w[ACC_W-1]) &
                                       (add_w[ACC_W-1] != x_w[ACC_W-1]))
                                    : add_w[ACC_W]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= '0;
      out_mode_q  <= 1'b0;
      seen_q      <= 1'b0;
    end else if (en_w) begin
      out_valid_q <= sv_q;
      if (sv_q) begin
        acc_q      <= acc_d;
        ovf_q      <= ovf_d;
        out_mode_q <= sm_q;
        seen_q     <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_simd_mac_pipelined_param.sv
// Directed bench for simd_mac_pipelined_param: hand-computed results go into an
// expected queue that a negedge monitor drains on every output handshake.
module tb_simd_mac_pipelined_param;

  localparam int LANE  = 9;
  localparam int NA    = 3;
  localparam int NB    = 2;
  localparam int PS    = 2;
  localparam int ACC_W = 48;
  localparam int WIN   = NA * NB * LANE;
  localparam int EW    = NB * ACC_W + NB + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIN-1:0]     a;
  logic [WIN-1:0]     b;
  logic               a_sign;
  logic               b_sign;
  logic               mode;
  logic               first;
  logic               out_valid;
  logic               out_ready;
  logic [NB*ACC_W-1:0] result;
  logic [NB-1:0]      overflow;
  logic               out_mode;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  simd_mac_pipelined_param #(
    .LANE(LANE), .NA(NA), .NB(NB), .PIPE_STAGES(PS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .first(first),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .out_mode(out_mode)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [ACC_W-1:0] c1, input logic [ACC_W-1:0] c0,
                                       input logic [NB-1:0] ov, input logic md);
    return {c1, c0, ov, md};
  endfunction

  function automatic logic [WIN-1:0] splat(input logic [LANE-1:0] v);
    logic [WIN-1:0] r;
    r = '0;
    for (int m = 0; m < NA*NB; m++) r[m*LANE +: LANE] = v;
    return r;
  endfunction

  // scoreboard: a handshake completes on the posedge after a negedge with valid & ready
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", result);
      end
      if (exp_q.size() > 0) chk("result", {result, overflow, out_mode}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic present(input logic md, input logic fst, input logic sa, input logic sb,
                         input logic [WIN-1:0] av, input logic [WIN-1:0] bv);
    mode = md; first = fst; a_sign = sa; b_sign = sb; a = av; b = bv;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept", EW'(in_ready), EW'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic md, input logic fst, input logic sa, input logic sb,
                      input logic [WIN-1:0] av, input logic [WIN-1:0] bv);
    present(md, fst, sa, sb, av, bv);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", EW'(exp_q.size()), EW'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0; mode = 1'b0; first = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", EW'(out_valid), EW'(1'b0));
    chk("rst_state", {result, overflow, out_mode}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", EW'(in_ready), EW'(1'b1));

    // 1: FULL signed -1 * 2 with latency check
    exp_q.push_back(pk(48'h0, 48'hFFFF_FFFF_FFFE, 2'b00, 1'b0));
    send(1'b0, 1'b1, 1'b1, 1'b1, WIN'(27'h7FF_FFFF), WIN'(18'd2));
    for (int c = 0; c <= PS; c++) begin
      chk("latency_idle", EW'(out_valid), EW'(1'b0));
      @(posedge clk);
      #1;
    end
    chk("latency_valid", EW'(out_valid), EW'(1'b1));
    drain();

    // 2: SIMD unsigned accumulate, 3*5*3 per beat per channel
    exp_q.push_back(pk(48'd45,  48'd45,  2'b00, 1'b1));
    exp_q.push_back(pk(48'd90,  48'd90,  2'b00, 1'b1));
    exp_q.push_back(pk(48'd135, 48'd135, 2'b00, 1'b1));
    send(1'b1, 1'b1, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    send(1'b1, 1'b0, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    send(1'b1, 1'b0, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    drain();

    // 3: backpressure, FULL unsigned k*10 accumulated
    exp_q.push_back(pk(48'd0, 48'd10,  2'b00, 1'b0));
    exp_q.push_back(pk(48'd0, 48'd30,  2'b00, 1'b0));
    exp_q.push_back(pk(48'd0, 48'd60,  2'b00, 1'b0));
    exp_q.push_back(pk(48'd0, 48'd100, 2'b00, 1'b0));
    exp_q.push_back(pk(48'd0, 48'd150, 2'b00, 1'b0));
    exp_q.push_back(pk(48'd0, 48'd210, 2'b00, 1'b0));
    send(1'b0, 1'b1, 1'b0, 1'b0, WIN'(1), WIN'(10));
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(2), WIN'(10));
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(3), WIN'(10));
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(4), WIN'(10));
    out_ready = 1'b0;
    present(1'b0, 1'b0, 1'b0, 1'b0, WIN'(5), WIN'(10));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", EW'(in_ready), EW'(1'b0));
      chk("stall_out_valid", EW'(out_valid), EW'(1'b1));
      chk("stall_hold", {result, overflow, out_mode}, pk(48'd0, 48'd10, 2'b00, 1'b0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept();
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(6), WIN'(10));
    drain();

    // 4: FULL signed (-2^26)*(-2^17) = 2^43; 16th beat overflows, next first clears
    for (int n = 1; n <= 16; n++) begin
      exp_q.push_back(pk(48'd0, ACC_W'(n) << 43, (n == 16) ? 2'b01 : 2'b00, 1'b0));
      send(1'b0, n == 1, 1'b1, 1'b1, WIN'(27'h400_0000), WIN'(18'h2_0000));
    end
    exp_q.push_back(pk(48'd0, 48'h0800_0000_0000, 2'b00, 1'b0));
    send(1'b0, 1'b1, 1'b1, 1'b1, WIN'(27'h400_0000), WIN'(18'h2_0000));
    drain();

    // 5: mode switch SIMD -> FULL with first=0 loads the bare product
    exp_q.push_back(pk(48'd45, 48'd45,  2'b00, 1'b1));
    exp_q.push_back(pk(48'd0,  48'd700, 2'b00, 1'b0));
    send(1'b1, 1'b1, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(100), WIN'(7));
    drain();

    // SIMD signed A=-1, B=3 unsigned: -9 per channel, no borrow across channels
    exp_q.push_back(pk(48'hFFFF_FFFF_FFF7, 48'hFFFF_FFFF_FFF7, 2'b00, 1'b1));
    send(1'b1, 1'b1, 1'b1, 1'b0, splat(9'h1FF), splat(9'd3));
    // SIMD unsigned maximum lanes: 3*511*511, then doubled
    exp_q.push_back(pk(48'h0B_F403, 48'h0B_F403, 2'b00, 1'b1));
    exp_q.push_back(pk(48'h17_E806, 48'h17_E806, 2'b00, 1'b1));
    send(1'b1, 1'b1, 1'b0, 1'b0, splat(9'h1FF), splat(9'h1FF));
    send(1'b1, 1'b0, 1'b0, 1'b0, splat(9'h1FF), splat(9'h1FF));
    drain();

    // 6: reset with two beats in flight discards them
    send(1'b1, 1'b1, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    send(1'b1, 1'b0, 1'b0, 1'b0, splat(9'd3), splat(9'd5));
    reset = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", EW'(out_valid), EW'(1'b0));
    chk("flush_result", EW'(result), EW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("flush_no_stale", EW'(out_valid), EW'(1'b0));
    exp_q.push_back(pk(48'd0, 48'd30, 2'b00, 1'b0));
    send(1'b0, 1'b0, 1'b0, 1'b0, WIN'(5), WIN'(6));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
